// File: rtl/pic_sched_if.sv
// CPU-side port bus and interrupt handshake of the pic_sched interrupt scheduler.
interface pic_sched_if;
    logic        port_clk;
    logic [15:0] port;
    logic [7:0]  port_o;
    logic        port_w;
    logic [7:0]  port_i;
    logic [7:0]  irq_line;
    logic        intr;
    logic [7:0]  irq;
    logic        intr_latch;

    modport master (
        output port_clk, port, port_o, port_w, irq_line, intr_latch,
        input  port_i, intr, irq
    );

    modport slave (
        input  port_clk, port, port_o, port_w, irq_line, intr_latch,
        output port_i, intr, irq
    );
endinterface

// File: rtl/pic_sched.sv
// 8-input 8259-style interrupt scheduler: edge capture, fixed priority with nesting, toggle handshake.
// Optional macro PIC_AUTO_EOI_EN: the ack retires the request without setting ISR.
module pic_sched #(
    parameter logic [15:0] PORT_BASE  = 16'h0020,
    parameter logic [7:0]  VECT_RESET = 8'h08
) (
    input  logic        clock,
    input  logic        resetn,
    pic_sched_if.slave  bus
);
`ifdef PIC_AUTO_EOI_EN
    localparam logic AUTO_EOI = 1'b1;
`else
    localparam logic AUTO_EOI = 1'b0;
`endif

    typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [7:0]  imr_q, imr_d;
    logic [7:0]  irr_q, irr_d;
    logic [7:0]  isr_q, isr_d;
    logic [4:0]  base_q, base_d;
    logic        rsel_q, rsel_d;
    logic        init_pend_q, init_pend_d;
    logic [7:0]  irq_prev_q;
    logic [2:0]  cur_q, cur_d;
    logic        intr_q, intr_d;
    logic [7:0]  irq_q, irq_d;
    logic [7:0]  port_i_q, port_i_d;

    logic        wr_cmd_s, wr_mask_s, rd_cmd_s, rd_mask_s;
    logic        ack_s;
    logic [7:0]  edge_s, isr_low_s, cand_s, cur_hot_s;

    function automatic logic [7:0] lowest_one(input logic [7:0] v);
        return v & (~v + 8'd1);
    endfunction

    function automatic logic [2:0] lowest_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                idx = i[2:0];
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    assign wr_cmd_s  = bus.port_clk &  bus.port_w & (bus.port == PORT_BASE);
    assign wr_mask_s = bus.port_clk &  bus.port_w & (bus.port == (PORT_BASE + 16'd1));
    assign rd_cmd_s  = bus.port_clk & ~bus.port_w & (bus.port == PORT_BASE);
    assign rd_mask_s = bus.port_clk & ~bus.port_w & (bus.port == (PORT_BASE + 16'd1));

    assign edge_s    = bus.irq_line & ~irq_prev_q;
    assign isr_low_s = lowest_one(isr_q);
    // Bits strictly below the lowest in-service level; wraps to all-ones when ISR is empty.
    assign cand_s    = irr_q & ~imr_q & (isr_low_s - 8'd1);
    assign cur_hot_s = 8'h01 << cur_q;

    assign bus.intr   = intr_q;
    assign bus.irq    = irq_q;
    assign bus.port_i = port_i_q;

    // Presentation FSM: issue a vector, then wait for the CPU to echo intr.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        intr_d  = intr_q;
        irq_d   = irq_q;
        ack_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|cand_s) begin
                    cur_d   = lowest_idx(cand_s);
                    irq_d   = {base_q, lowest_idx(cand_s)};
                    intr_d  = ~bus.intr_latch;
                    state_d = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (bus.intr_latch == intr_q) begin
                    ack_s   = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Register file updates from port writes, captured edges and the ack.
    always_comb begin
        imr_d       = imr_q;
        isr_d       = isr_q;
        base_d      = base_q;
        rsel_d      = rsel_q;
        init_pend_d = init_pend_q;
        port_i_d    = port_i_q;
        // A new edge on the acked line wins over the ack clear.
        irr_d       = (irr_q & ~(ack_s ? cur_hot_s : 8'h00)) | edge_s;

        if (wr_cmd_s) begin
            if (bus.port_o[4]) begin
                imr_d       = 8'h00;
                isr_d       = 8'h00;
                init_pend_d = 1'b1;
                rsel_d      = 1'b0;
            end else if (bus.port_o[7:5] == 3'b001) begin
                isr_d = isr_q & ~isr_low_s;
            end else if (bus.port_o[7:5] == 3'b011) begin
                isr_d = isr_q & ~(8'h01 << bus.port_o[2:0]);
            end else if (bus.port_o[3]) begin
                if (bus.port_o[1:0] == 2'b10) begin
                    rsel_d = 1'b0;
                end else if (bus.port_o[1:0] == 2'b11) begin
                    rsel_d = 1'b1;
                end else begin
                    rsel_d = rsel_q;
                end
            end else begin
                isr_d = isr_q;
            end
        end else if (wr_mask_s) begin
            if (init_pend_q) begin
                base_d      = bus.port_o[7:3];
                init_pend_d = 1'b0;
            end else begin
                imr_d = bus.port_o;
            end
        end else begin
            imr_d = imr_q;
        end

        if (ack_s && !AUTO_EOI) begin
            isr_d = isr_d | cur_hot_s;
        end else begin
            isr_d = isr_d;
        end

        if (rd_cmd_s) begin
            port_i_d = rsel_q ? isr_q : irr_q;
        end else if (rd_mask_s) begin
            port_i_d = imr_q;
        end else begin
            port_i_d = port_i_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            imr_q       <= 8'h00;
            irr_q       <= 8'h00;
            isr_q       <= 8'h00;
            base_q      <= VECT_RESET[7:3];
            rsel_q      <= 1'b0;
            init_pend_q <= 1'b0;
            irq_prev_q  <= 8'h00;
            cur_q       <= 3'd0;
            intr_q      <= 1'b0;
            irq_q       <= VECT_RESET;
            port_i_q    <= 8'h00;
        end else begin
            state_q     <= state_d;
            imr_q       <= imr_d;
            irr_q       <= irr_d;
            isr_q       <= isr_d;
            base_q      <= base_d;
            rsel_q      <= rsel_d;
            init_pend_q <= init_pend_d;
            irq_prev_q  <= bus.irq_line;
            cur_q       <= cur_d;
            intr_q      <= intr_d;
            irq_q       <= irq_d;
            port_i_q    <= port_i_d;
        end
    end
endmodule

// File: tb/tb_pic_sched.sv
// Directed bench for pic_sched: priority, nesting, masking, ICW1 re-base, reset mid-handshake.
module tb_pic_sched;
    logic clock  = 1'b0;
    logic resetn = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    pic_sched_if bus ();

    pic_sched dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [15:0] addr, input logic [7:0] data);
        bus.port_clk = 1'b1;
        bus.port_w   = 1'b1;
        bus.port     = addr;
        bus.port_o   = data;
        tick();
        bus.port_clk = 1'b0;
        bus.port_w   = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [15:0] addr, input logic [7:0] exp);
        bus.port_clk = 1'b1;
        bus.port_w   = 1'b0;
        bus.port     = addr;
        tick();
        bus.port_clk = 1'b0;
        check(tag, bus.port_i, exp);
    endtask

    task automatic pulse(input logic [7:0] lines);
        bus.irq_line = lines;
        tick();
        bus.irq_line = 8'h00;
    endtask

    initial begin
        bus.port_clk   = 1'b0;
        bus.port       = 16'h0000;
        bus.port_o     = 8'h00;
        bus.port_w     = 1'b0;
        bus.irq_line   = 8'h00;
        bus.intr_latch = 1'b0;
        #1 resetn = 1'b0;
        #1;
        check("rst_intr", {7'd0, bus.intr}, 8'h00);
        check("rst_irq", bus.irq, 8'h08);
        check("rst_port_i", bus.port_i, 8'h00);
        tick();
        tick();
        resetn = 1'b1;
        tick();

        // Single request on line 1
        pulse(8'h02);
        check("t1_latency", {7'd0, bus.intr}, 8'h00);
        tick();
        check("t1_intr", {7'd0, bus.intr}, 8'h01);
        check("t1_irq", bus.irq, 8'h09);
        bus.intr_latch = 1'b1;
        tick();
        wr(16'h0020, 8'h0B);
        rd("t1_isr", 16'h0020, 8'h02);
        wr(16'h0020, 8'h0A);
        rd("t1_irr", 16'h0020, 8'h00);
        wr(16'h0020, 8'h20);
        wr(16'h0020, 8'h0B);
        rd("t1_isr_eoi", 16'h0020, 8'h00);

        // Lines 3 and 0 together: 0 first, 3 held off by ISR[0]
        pulse(8'h09);
        tick();
        check("t2_intr0", {7'd0, bus.intr}, 8'h00);
        check("t2_irq0", bus.irq, 8'h08);
        bus.intr_latch = 1'b0;
        tick();
        tick();
        tick();
        check("t2_blocked", {7'd0, bus.intr}, 8'h00);
        wr(16'h0020, 8'h20);
        check("t2_still_blocked", {7'd0, bus.intr}, 8'h00);
        tick();
        check("t2_intr3", {7'd0, bus.intr}, 8'h01);
        check("t2_irq3", bus.irq, 8'h0B);
        bus.intr_latch = 1'b1;
        tick();
        rd("t2_isr", 16'h0020, 8'h08);

        // Nesting: line 1 preempts in-service line 3
        pulse(8'h02);
        tick();
        check("t3_intr", {7'd0, bus.intr}, 8'h00);
        check("t3_irq", bus.irq, 8'h09);
        bus.intr_latch = 1'b0;
        tick();
        rd("t3_isr_nested", 16'h0020, 8'h0A);
        wr(16'h0020, 8'h20);
        rd("t3_isr_eoi1", 16'h0020, 8'h08);
        wr(16'h0020, 8'h20);
        rd("t3_isr_eoi2", 16'h0020, 8'h00);

        // Masking holds the request pending
        wr(16'h0021, 8'h02);
        pulse(8'h02);
        tick();
        tick();
        check("t4_masked", {7'd0, bus.intr}, 8'h00);
        wr(16'h0020, 8'h0A);
        rd("t4_irr", 16'h0020, 8'h02);
        rd("t4_imr", 16'h0021, 8'h02);
        wr(16'h0021, 8'h00);
        tick();
        check("t4_intr", {7'd0, bus.intr}, 8'h01);
        check("t4_irq", bus.irq, 8'h09);
        bus.intr_latch = 1'b1;
        tick();
        wr(16'h0020, 8'h20);

        // ICW1 re-base to 0x70, then specific EOI
        wr(16'h0020, 8'h11);
        wr(16'h0021, 8'h70);
        pulse(8'h10);
        tick();
        check("t5_intr", {7'd0, bus.intr}, 8'h00);
        check("t5_irq", bus.irq, 8'h74);
        rd("t5_imr", 16'h0021, 8'h00);
        bus.intr_latch = 1'b0;
        tick();
        wr(16'h0020, 8'h0B);
        rd("t5_isr", 16'h0020, 8'h10);
        wr(16'h0020, 8'h64);
        rd("t5_isr_seoi", 16'h0020, 8'h00);

        // Reset while waiting for the ack
        pulse(8'h08);
        tick();
        check("t6_intr", {7'd0, bus.intr}, 8'h01);
        check("t6_irq", bus.irq, 8'h73);
        #2 resetn = 1'b0;
        #1;
        check("t6_rst_intr", {7'd0, bus.intr}, 8'h00);
        check("t6_rst_irq", bus.irq, 8'h08);
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        check("t6_no_reissue", {7'd0, bus.intr}, 8'h00);
        check("t6_irq_idle", bus.irq, 8'h08);
        rd("t6_irr", 16'h0020, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
